ifetch_unit: RTL and testbench

IFETCH_UNIT -- requirements
Module: ifetch_unit

---
 rtl/ifetch_unit.sv | 138 +++++++++++++
 tb/tb_ifetch_unit.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/ifetch_unit.sv
// Instruction fetch unit: one outstanding memory read, single instruction buffer toward decode.
// Optional misaligned-PC trap enabled by defining FETCH_MISALIGN_TRAP_EN.
`timescale 1ns/1ps
module ifetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] ADDR_MASK = 32'h0000_FFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] next_pc,
  input  logic        flush,
  output logic [31:0] now_pc,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] fetch_cnt,
  output logic        fault
);

`ifdef FETCH_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_HOLD  = 2'd1,
    S_DROP  = 2'd2,
    S_FAULT = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] now_pc_q, now_pc_d;
  logic [31:0] pend_pc_q, pend_pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic        fault_q, fault_d;

  logic [31:0] masked_pc;
  logic [31:0] tgt_pc;
  logic        tgt_misalign;
  logic        pc_load;

  // Without the trap, the low two bits are dropped so every fetch address is word aligned.
  assign masked_pc    = next_pc & ADDR_MASK;
  assign tgt_pc       = TRAP_EN ? masked_pc : {masked_pc[31:2], 2'b00};
  assign tgt_misalign = (next_pc[1:0] != 2'b00);

  always_comb begin
    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latches).
    state_d     = state_q;
    now_pc_d    = now_pc_q;
    pend_pc_d   = pend_pc_q;
    inst_d      = inst_q;
    fetch_cnt_d = fetch_cnt_q;
    fault_d     = fault_q;
    pc_load     = 1'b0;

    case (state_q)
      S_REQ: begin
        if (imem_ack) begin
          if (flush) begin
            now_pc_d = tgt_pc;
            pc_load  = 1'b1;
          end else begin
            inst_d  = imem_rdata;
            state_d = S_HOLD;
          end
        end else if (flush) begin
          // The read is already on the bus; remember the target and swallow its response.
          pend_pc_d = tgt_pc;
          pc_load   = 1'b1;
          state_d   = S_DROP;
        end
      end
      S_HOLD: begin
        if (inst_ready) fetch_cnt_d = fetch_cnt_q + 32'd1;
        if (inst_ready || flush) begin
          now_pc_d = tgt_pc;
          pc_load  = 1'b1;
          state_d  = S_REQ;
        end
      end
      S_DROP: begin
        if (flush) begin
          pend_pc_d = tgt_pc;
          pc_load   = 1'b1;
        end
        if (imem_ack) begin
          now_pc_d = flush ? tgt_pc : pend_pc_q;
          state_d  = S_REQ;
        end
      end
      S_FAULT: ;
      default: state_d = S_REQ;
    endcase

    if (TRAP_EN && pc_load && tgt_misalign) begin
      now_pc_d = tgt_pc;
      fault_d  = 1'b1;
      state_d  = S_FAULT;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      state_q     <= S_REQ;
      now_pc_q    <= RESET_PC & ADDR_MASK;
      pend_pc_q   <= 32'd0;
      inst_q      <= 32'd0;
      fetch_cnt_q <= 32'd0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      now_pc_q    <= now_pc_d;
      pend_pc_q   <= pend_pc_d;
      inst_q      <= inst_d;
      fetch_cnt_q <= fetch_cnt_d;
      fault_q     <= fault_d;
    end
  end

  // Requests are held off while reset is asserted; the first one appears after release.
  assign imem_req   = ((state_q == S_REQ) || (state_q == S_DROP)) && !rst;
  assign inst_valid = (state_q == S_HOLD);
  assign imem_addr  = now_pc_q[15:0];
  assign now_pc     = now_pc_q;
  assign inst       = inst_q;
  assign fetch_cnt  = fetch_cnt_q;
  assign fault      = fault_q;

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit: vector table for the main flow, hand sequences for
// misalignment, counter wrap and reset during a dropped request.
`timescale 1ns/1ps
module tb_ifetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] next_pc;
  logic        flush;
  logic [31:0] now_pc;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] fetch_cnt;
  logic        fault;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ifetch_unit dut (
    .clk        (clk),
    .rst        (rst),
    .next_pc    (next_pc),
    .flush      (flush),
    .now_pc     (now_pc),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .inst_valid (inst_valid),
    .inst_ready (inst_ready),
    .inst       (inst),
    .fetch_cnt  (fetch_cnt),
    .fault      (fault)
  );

  typedef struct packed {
    logic        flush;
    logic [31:0] next_pc;
    logic        ack;
    logic [31:0] rdata;
    logic        ready;
    logic        e_req;
    logic        e_valid;
    logic [15:0] e_addr;
    logic [31:0] e_pc;
    logic [31:0] e_inst;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t vecs [21];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Inputs change 1ns after the rising edge; outputs are sampled at the same point.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic f, input logic [31:0] npc, input logic a,
                       input logic [31:0] rd, input logic rdy);
    flush      = f;
    next_pc    = npc;
    imem_ack   = a;
    imem_rdata = rd;
    inst_ready = rdy;
  endtask

  initial begin
    //            flush next_pc      ack rdata         rdy req val addr      pc            inst          cnt
    vecs[0]  = '{1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 16'h0000, 32'h0000_0000, 32'h0000_0000, 32'd0};
    vecs[1]  = '{1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 16'h0000, 32'h0000_0000, 32'h0000_0000, 32'd0};
    vecs[2]  = '{1'b0, 32'h0,        1'b1, 32'h0000_0013, 1'b0, 1'b0, 1'b1, 16'h0000, 32'h0000_0000, 32'h0000_0013, 32'd0};
    vecs[3]  = '{1'b0, 32'h4,        1'b1, 32'hBAD0_BAD0, 1'b0, 1'b0, 1'b1, 16'h0000, 32'h0000_0000, 32'h0000_0013, 32'd0};
    vecs[4]  = '{1'b0, 32'h4,        1'b1, 32'hBAD0_BAD0, 1'b0, 1'b0, 1'b1, 16'h0000, 32'h0000_0000, 32'h0000_0013, 32'd0};
    vecs[5]  = '{1'b0, 32'h4,        1'b0, 32'hBAD0_BAD0, 1'b0, 1'b0, 1'b1, 16'h0000, 32'h0000_0000, 32'h0000_0013, 32'd0};
    vecs[6]  = '{1'b0, 32'h4,        1'b1, 32'hBAD0_BAD0, 1'b0, 1'b0, 1'b1, 16'h0000, 32'h0000_0000, 32'h0000_0013, 32'd0};
    vecs[7]  = '{1'b0, 32'h4,        1'b0, 32'hBAD0_BAD0, 1'b0, 1'b0, 1'b1, 16'h0000, 32'h0000_0000, 32'h0000_0013, 32'd0};
    vecs[8]  = '{1'b0, 32'h4,        1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 16'h0004, 32'h0000_0004, 32'h0000_0013, 32'd1};
    vecs[9]  = '{1'b1, 32'h40,       1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 16'h0004, 32'h0000_0004, 32'h0000_0013, 32'd1};
    vecs[10] = '{1'b0, 32'h44,       1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 16'h0004, 32'h0000_0004, 32'h0000_0013, 32'd1};
    vecs[11] = '{1'b0, 32'h44,       1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b0, 16'h0040, 32'h0000_0040, 32'h0000_0013, 32'd1};
    vecs[12] = '{1'b0, 32'h44,       1'b1, 32'h0010_0093, 1'b0, 1'b0, 1'b1, 16'h0040, 32'h0000_0040, 32'h0010_0093, 32'd1};
    vecs[13] = '{1'b1, 32'h1234_0100, 1'b0, 32'h0,       1'b0, 1'b1, 1'b0, 16'h0100, 32'h0000_0100, 32'h0010_0093, 32'd1};
    vecs[14] = '{1'b1, 32'h200,      1'b1, 32'h0BAD_F00D, 1'b0, 1'b1, 1'b0, 16'h0200, 32'h0000_0200, 32'h0010_0093, 32'd1};
    vecs[15] = '{1'b0, 32'h204,      1'b1, 32'hAAAA_5555, 1'b0, 1'b0, 1'b1, 16'h0200, 32'h0000_0200, 32'hAAAA_5555, 32'd1};
    vecs[16] = '{1'b1, 32'h300,      1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 16'h0300, 32'h0000_0300, 32'hAAAA_5555, 32'd2};
    vecs[17] = '{1'b1, 32'h500,      1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 16'h0300, 32'h0000_0300, 32'hAAAA_5555, 32'd2};
    vecs[18] = '{1'b1, 32'h600,      1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 16'h0300, 32'h0000_0300, 32'hAAAA_5555, 32'd2};
    vecs[19] = '{1'b0, 32'h700,      1'b1, 32'h0,        1'b0, 1'b1, 1'b0, 16'h0600, 32'h0000_0600, 32'hAAAA_5555, 32'd2};
    vecs[20] = '{1'b0, 32'h700,      1'b1, 32'h1111_1111, 1'b0, 1'b0, 1'b1, 16'h0600, 32'h0000_0600, 32'h1111_1111, 32'd2};

    // Reset with a stray ack present; it must not be captured.
    rst = 1'b1;
    drive(1'b0, 32'h0, 1'b1, 32'hFFFF_FFFF, 1'b0);
    tick();
    check("rst_req_low", {31'd0, imem_req}, 32'd0);
    tick();
    rst = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    #1;
    check("rst_pc", now_pc, 32'h0);
    check("rst_valid", {31'd0, inst_valid}, 32'd0);
    check("rst_inst", inst, 32'h0);
    check("rst_cnt", fetch_cnt, 32'd0);
    check("rst_fault", {31'd0, fault}, 32'd0);
    check("rst_first_req", {31'd0, imem_req}, 32'd1);

    for (int i = 0; i < 21; i++) begin
      drive(vecs[i].flush, vecs[i].next_pc, vecs[i].ack, vecs[i].rdata, vecs[i].ready);
      tick();
      check($sformatf("v%0d_req", i),   {31'd0, imem_req},   {31'd0, vecs[i].e_req});
      check($sformatf("v%0d_valid", i), {31'd0, inst_valid}, {31'd0, vecs[i].e_valid});
      check($sformatf("v%0d_addr", i),  {16'd0, imem_addr},  {16'd0, vecs[i].e_addr});
      check($sformatf("v%0d_pc", i),    now_pc,              vecs[i].e_pc);
      check($sformatf("v%0d_inst", i),  inst,                vecs[i].e_inst);
      check($sformatf("v%0d_cnt", i),   fetch_cnt,           vecs[i].e_cnt);
    end

    // Misaligned target accepted from HOLD.
    drive(1'b0, 32'h0000_0102, 1'b0, 32'h0, 1'b1);
    tick();
    check("mis_cnt", fetch_cnt, 32'd3);
`ifdef FETCH_MISALIGN_TRAP_EN
    check("mis_fault", {31'd0, fault}, 32'd1);
    check("mis_req", {31'd0, imem_req}, 32'd0);
    check("mis_pc", now_pc, 32'h0000_0102);
    drive(1'b0, 32'h0, 1'b1, 32'h0, 1'b1);
    for (int k = 0; k < 3; k++) tick();
    check("mis_sticky_fault", {31'd0, fault}, 32'd1);
    check("mis_sticky_req", {31'd0, imem_req}, 32'd0);
    check("mis_sticky_valid", {31'd0, inst_valid}, 32'd0);
`else
    check("mis_fault", {31'd0, fault}, 32'd0);
    check("mis_addr", {16'd0, imem_addr}, 32'h0000_0100);
    check("mis_req", {31'd0, imem_req}, 32'd1);
`endif
    rst = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    tick();
    rst = 1'b0;
    check("rst2_fault", {31'd0, fault}, 32'd0);
    check("rst2_cnt", fetch_cnt, 32'd0);

    // Counter wrap: preload all-ones while holding, then complete one transfer.
    drive(1'b0, 32'h0, 1'b1, 32'h0000_0033, 1'b0);
    tick();
    drive(1'b0, 32'h8, 1'b0, 32'h0, 1'b0);
    check("wrap_hold", {31'd0, inst_valid}, 32'd1);
    force dut.fetch_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.fetch_cnt_q;
    #1;
    check("wrap_pre", fetch_cnt, 32'hFFFF_FFFF);
    inst_ready = 1'b1;
    tick();
    check("wrap_cnt", fetch_cnt, 32'd0);
    check("wrap_addr", {16'd0, imem_addr}, 32'h0000_0008);

    // Reset while a dropped request is outstanding.
    drive(1'b1, 32'h700, 1'b0, 32'h0, 1'b0);
    tick();
    check("drop_addr", {16'd0, imem_addr}, 32'h0000_0008);
    rst = 1'b1;
    drive(1'b0, 32'h0, 1'b1, 32'h5555_AAAA, 1'b0);
    tick();
    check("drop_rst_pc", now_pc, 32'h0);
    check("drop_rst_valid", {31'd0, inst_valid}, 32'd0);
    rst = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    #1;
    check("drop_rst_req", {31'd0, imem_req}, 32'd1);
    drive(1'b0, 32'h0, 1'b1, 32'h0000_0077, 1'b0);
    tick();
    check("drop_rst_inst", inst, 32'h0000_0077);
    check("drop_rst_hold", {31'd0, inst_valid}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
